// File: rtl/median_pkg.sv
// ============================================================================
// Module   : median_pkg
// Brief    : Shared FSM state type and counter-width helper for the 3x3 median
//            window controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package median_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int c_IMG_WIDTH_DEF  = 640;
    localparam int c_IMG_HEIGHT_DEF = 480;

    // Width of a counter spanning 0..n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/median_line_buf.sv
// ============================================================================
// Module   : median_line_buf
// Brief    : Single-port line buffer. The old word is read combinationally and
//            the new word is written on the same edge (write-before-shift).
// Revision : 1.0
// ============================================================================
`default_nettype none

module median_line_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640,
    parameter int ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/median_net.sv
// ============================================================================
// Module   : median_net
// Brief    : Combinational 19-node compare-exchange network returning the
//            median of nine taps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module median_net #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [8:0][DATA_WIDTH-1:0] i_taps,
    output logic [DATA_WIDTH-1:0]      o_med
);

    // Each node leaves the smaller value at c_LO and the larger at c_HI.
    localparam logic [3:0] c_LO [19] = '{4'd1, 4'd4, 4'd7, 4'd0, 4'd3, 4'd6, 4'd1,
                                         4'd4, 4'd7, 4'd0, 4'd5, 4'd4, 4'd3, 4'd1,
                                         4'd2, 4'd4, 4'd4, 4'd6, 4'd4};
    localparam logic [3:0] c_HI [19] = '{4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd2,
                                         4'd5, 4'd8, 4'd3, 4'd8, 4'd7, 4'd6, 4'd4,
                                         4'd5, 4'd7, 4'd2, 4'd4, 4'd2};

    logic [8:0][DATA_WIDTH-1:0] w_v;
    logic [DATA_WIDTH-1:0]      w_t;

    always_comb begin
        w_v = i_taps;
        w_t = '0;
        for (int k = 0; k < 19; k++) begin
            if (w_v[c_LO[k]] > w_v[c_HI[k]]) begin
                w_t            = w_v[c_LO[k]];
                w_v[c_LO[k]]   = w_v[c_HI[k]];
                w_v[c_HI[k]]   = w_t;
            end
        end
        o_med = w_v[4];
    end

endmodule

`default_nettype wire

// File: rtl/median_window_ctrl.sv
// ============================================================================
// Module   : median_window_ctrl
// Brief    : Streaming 3x3 median filter controller with line buffers, window
//            register and valid/ready handshake. Optional centre-tap bypass
//            port when MEDIAN_BYPASS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module median_window_ctrl
    import median_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = c_IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = c_IMG_HEIGHT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef MEDIAN_BYPASS_EN
    input  logic                  bypass,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol
);

    localparam int c_COL_W = cnt_width(IMG_WIDTH);
    localparam int c_ROW_W = cnt_width(IMG_HEIGHT);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

    state_t                     r_state, w_state_nxt;
    logic [c_COL_W-1:0]         r_col, w_pix_col;
    logic [c_ROW_W-1:0]         r_row;
    logic [8:0][DATA_WIDTH-1:0] r_win, w_win_nxt;
    logic [DATA_WIDTH-1:0]      w_lb0_rd, w_lb1_rd, w_med, w_out_pix;
    logic                       r_out_valid, r_out_sof, r_out_eol;
    logic [DATA_WIDTH-1:0]      r_out_data;
    logic                       w_accept, w_last_pix, w_advance, w_produce;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_last_pix = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
    // A start-of-frame pixel is always column 0, whatever the counters hold.
    assign w_pix_col  = in_sof ? '0 : r_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (in_sof) begin
                w_state_nxt = ST_FILL;
            end else begin
                case (r_state)
                    ST_FILL: if (r_row == c_ROW_TWO && r_col == '0) w_state_nxt = ST_RUN;
                    ST_RUN:  if (w_last_pix) w_state_nxt = ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_advance = w_accept && (in_sof || (r_state != ST_IDLE));
        w_produce = w_accept && !in_sof && (r_state == ST_RUN) && (r_col >= c_COL_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_advance) begin
            if (in_sof) begin
                r_row <= '0;
                r_col <= c_COL_W'(1);
            end else if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + c_ROW_W'(1);
            end else begin
                r_col <= r_col + c_COL_W'(1);
            end
        end
    end

    median_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (c_COL_W)
    ) u_lb0 (
        .clk     (clk),
        .i_we    (w_advance),
        .i_addr  (w_pix_col),
        .i_wdata (in_data),
        .o_rdata (w_lb0_rd)
    );

    median_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (c_COL_W)
    ) u_lb1 (
        .clk     (clk),
        .i_we    (w_advance),
        .i_addr  (w_pix_col),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    // Taps 0..8 = a0 a1 a2 b0 b1 b2 c0 c1 c2; the median sees the post-shift
    // window so the result can be registered on the accepting edge.
    always_comb begin
        w_win_nxt[0] = r_win[1];
        w_win_nxt[1] = r_win[2];
        w_win_nxt[2] = w_lb1_rd;
        w_win_nxt[3] = r_win[4];
        w_win_nxt[4] = r_win[5];
        w_win_nxt[5] = w_lb0_rd;
        w_win_nxt[6] = r_win[7];
        w_win_nxt[7] = r_win[8];
        w_win_nxt[8] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (w_advance) begin
            r_win <= w_win_nxt;
        end
    end

    median_net #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_med (
        .i_taps (w_win_nxt),
        .o_med  (w_med)
    );

`ifdef MEDIAN_BYPASS_EN
    assign w_out_pix = bypass ? w_win_nxt[4] : w_med;
`else
    assign w_out_pix = w_med;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
        end else if (w_produce) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_pix;
            r_out_sof   <= (r_row == c_ROW_TWO) && (r_col == c_COL_TWO);
            r_out_eol   <= (r_col == c_COL_LAST);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;

endmodule

`default_nettype wire

// File: doc/median_window_ctrl.md
MEDIAN_WINDOW_CTRL -- requirements
Module: median_window_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, pixels per line, legal range 3..4096.
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, lines per frame, legal range 3..4096.
REQ-004 SHALL have port clk  input  1  single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  input pixel valid.
REQ-007 SHALL have port in_ready  output  1  input pixel accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port in_sof  input  1  start of frame, qualified with in_valid.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  raster-order pixel.
REQ-010 SHALL have port out_valid  output  1  filtered pixel valid.
REQ-011 SHALL have port out_ready  input  1  downstream ready.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  3x3 median.
REQ-013 SHALL have port out_sof  output  1  first output pixel of the frame.
REQ-014 SHALL have port out_eol  output  1  last output pixel of a line.

Function
REQ-015 SHALL implement an FSM with states IDLE, FILL and RUN.
- IDLE->FILL on an accepted pixel with in_sof=1.
- FILL->RUN on the accepted pixel at row 2, col 0.
- RUN->IDLE on the accepted pixel at row IMG_HEIGHT-1, col IMG_WIDTH-1.
REQ-016 SHALL, in IDLE, accept and discard pixels with in_sof=0.
REQ-017 SHALL keep a column counter (0..IMG_WIDTH-1, wraps to 0 and increments row) and a row counter (0..IMG_HEIGHT-1); both advance only on an accepted pixel.
REQ-018 SHALL, when an accepted pixel has in_sof=1 in any state, restart the frame.
- Counters load row 0, col 1; that pixel is column 0.
- State goes to FILL.
- Any partial frame is dropped without output.
REQ-019 SHALL store the two previous lines in line buffers of depth IMG_WIDTH, read and written at address col.
REQ-020 SHALL shift a 3x3 window register on each accepted pixel.
- New column = {line_buf1[col], line_buf0[col], in_data}.
- Taps a0..c2 map row-major: a = oldest line, c = current line.
REQ-021 SHALL instantiate the existing combinational 19-node median network on the window taps.
REQ-022 SHALL produce one output for each accepted pixel with row>=2 and col>=2, giving an output frame of (IMG_WIDTH-2)x(IMG_HEIGHT-2).
REQ-023 SHALL register out_data one cycle after acceptance of the completing pixel (latency 1).
REQ-024 SHALL assert out_sof with the output for input (2,2) and out_eol with outputs for col=IMG_WIDTH-1.
REQ-025 SHALL hold out_valid, out_data, out_sof and out_eol stable while out_valid=1 and out_ready=0.
REQ-026 SHALL drive in_ready = !out_valid || out_ready, so an output and an input may transfer in the same cycle without a bubble.
REQ-027 SHALL clear out_valid on an output transfer unless a new output is produced in the same cycle.

Reset
REQ-028 SHALL, on rst_n low, immediately force the following: state=IDLE, counters=0, window=0, out_valid=0, out_data=0, out_sof=0, out_eol=0.
REQ-029 SHALL not require line-buffer contents to be reset; FILL guarantees they are written before they are used.
REQ-030 SHALL, on reset mid-frame, emit nothing further until the next in_sof.

Configuration
REQ-031 SHALL support macro MEDIAN_BYPASS_EN.
- Defined: adds input port bypass (1 bit, quasi-static). When bypass=1, out_data is the window centre tap b1 instead of the median; timing and handshake are unchanged.
- Undefined: no bypass port exists; out_data is always the median.

Structure
REQ-032 SHALL place the FSM state typedef, and the counter width constants derived with $clog2 of IMG_WIDTH and IMG_HEIGHT, in shared package median_pkg.
REQ-033 SHALL implement the line buffers as sub-module median_line_buf (single-port RAM, depth IMG_WIDTH, write-before-shift), instantiated once per line.

Verification
REQ-034 SHALL run the following directed scenarios with IMG_WIDTH=5 and IMG_HEIGHT=4.
- Ramp frame, pixel=row*5+col, out_ready=1: exactly 6 outputs, first = 6 with out_sof, eol at outputs 3 and 6, out_data = centre value.
- Constant 0 frame with a single 255 impulse at (1,1): all outputs 0 (impulse rejected).
- out_ready toggled 1/0 every cycle with continuous in_valid: same 6 values in order, no loss or duplicates, out_data stable while stalled.
- in_sof reasserted at row 1, col 3 mid-frame: no output from the dropped frame; the new frame yields the full 6 outputs.
- rst_n pulsed low at row 3: out_valid=0 immediately; pixels without in_sof produce no output.
- With MEDIAN_BYPASS_EN and bypass=1 on the ramp frame: outputs equal the centre taps 6, 7, 8, 11, 12, 13.
